config_loader: RTL and testbench
================================

Name: config_loader

Overview:
- Serial configuration loader that sits directly upstream of the fabric controller and produces the parallel bitfile it slices into per-cell control signals.
- Hunts a serial bit stream for a sync word, then shifts in one CFG_WIDTH-bit frame and checks its even parity bit.
- Commits the frame to the bitfile output only when the parity check passes, so the controller never sees a partial or corrupt configuration.

Parameters:
- CFG_WIDTH, 8: payload/bitfile width in bits.
- SYNC_WIDTH, 8: sync word length in bits.
- SYNC_WORD, 8'hA5: frame start pattern, MSB first.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_valid  input  1  cfg_bit is sampled on this edge.
- cfg_bit  input  1  serial configuration data, MSB first.
- cfg_abort  input  1  synchronous abort of the frame in progress.
- bitfile  output  CFG_WIDTH  active configuration, feeds the controller.
- cfg_busy  output  1  high while in LOAD or PARITY.
- cfg_done  output  1  one-cycle pulse: frame committed.
- cfg_error  output  1  one-cycle pulse: parity failure, frame discarded.
- cfg_loaded  output  1  sticky; high once any frame has been committed.

Behaviour:
- Reset (rst=1 at an edge):
  - state=HUNT; sync shift register, bit counter and shadow register cleared.
  - bitfile=0, cfg_done=0, cfg_error=0, cfg_busy=0, cfg_loaded=0.
  - Reset mid-frame discards the frame. Reset has priority over all inputs.
- Bits are consumed only on edges where cfg_valid=1. Gaps of any length are legal and state holds across them.
- HUNT:
  - Each valid bit shifts into the SYNC_WIDTH sync register (new bit enters the LSB).
  - When the updated value equals SYNC_WORD: go to LOAD, counter=0, sync register cleared.
  - Sync register is also cleared on every entry to HUNT, so bits from before a frame or abort never contribute to a match.
- LOAD:
  - Each valid bit shifts into the shadow register, MSB first, and the counter increments.
  - After the CFG_WIDTH-th bit: go to PARITY.
- PARITY:
  - The next valid bit is the parity bit.
  - Check: XOR of the shadow payload and the parity bit must be 0 (even parity).
  - Pass: at that edge bitfile<=shadow, cfg_done<=1 for exactly one cycle, cfg_loaded<=1.
  - Fail: cfg_error<=1 for exactly one cycle, bitfile unchanged.
  - Either way: go to HUNT.
- Latency: new bitfile and cfg_done are visible in the cycle after the edge that accepts the parity bit.
- cfg_busy is registered and equals (state==LOAD || state==PARITY).
- cfg_abort=1 (with rst=0):
  - Go to HUNT, clear sync register, counter and shadow. No pulses; bitfile and cfg_loaded unchanged.
  - Abort has priority over a simultaneous cfg_valid. An abort in HUNT only clears the sync register.
- bitfile changes only on reset or on a committed frame. It never shows intermediate shift contents.
- Counter width is clog2(CFG_WIDTH+1). No wrap is possible because the counter is reset on LOAD entry.
- Back-to-back frames are legal. The first sync bit may arrive on the cycle cfg_done is high.

Optional Feature:
- Macro: CFG_READBACK_EN.
- Defined:
  - Adds input rb_req and outputs rb_bit and rb_valid.
  - rb_req=1 while state==HUNT and no readback is active starts a readback: the current bitfile is latched and shifted out MSB first over CFG_WIDTH consecutive cycles on rb_bit, with rb_valid=1, beginning the cycle after rb_req.
  - rb_req is ignored while a readback is active or cfg_busy=1.
  - Reset clears rb_valid and rb_bit to 0. cfg_abort does not stop a readback.
- Not defined: the three ports and all readback logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then stream A5, 8'hB2, parity 0 (no gaps) -> cfg_done pulses once, bitfile=8'hB2, cfg_loaded=1, cfg_busy high for exactly 9 valid-bit edges.
- Same stream with parity 1 -> cfg_error pulses once, no cfg_done, bitfile stays 8'h00, cfg_loaded=0.
- Stream 0x5A, 0x3C, then A5, 8'h0F, parity 0, with cfg_valid toggled 1/0 every cycle -> no false sync; bitfile=8'h0F committed once.
- After committing 8'hB2, send A5 plus 4 payload bits, assert cfg_abort, then A5, 8'h81, parity 0 -> bitfile stays B2 through the abort (no pulses), then becomes 8'h81.
- After committing 8'hB2, assert rst mid-LOAD -> bitfile=0, cfg_loaded=0, cfg_busy=0. Next full frame A5/8'h7E/parity 0 commits 8'h7E.
- With CFG_READBACK_EN, bitfile=8'hB2, pulse rb_req in HUNT -> rb_valid high for 8 cycles, rb_bit=1,0,1,1,0,0,1,0. A second rb_req during readback is ignored.

Source files
------------

// File: rtl/config_loader_if.sv
// rtl/config_loader_if.sv - Serial config stream and bitfile status bundle; readback ports under CFG_READBACK_EN
interface config_loader_if #(
  parameter int CFG_WIDTH = 8
);
  logic                 cfg_valid;
  logic                 cfg_bit;
  logic                 cfg_abort;
  logic [CFG_WIDTH-1:0] bitfile;
  logic                 cfg_busy;
  logic                 cfg_done;
  logic                 cfg_error;
  logic                 cfg_loaded;
`ifdef CFG_READBACK_EN
  logic                 rb_req;
  logic                 rb_bit;
  logic                 rb_valid;

  modport master (
    output cfg_valid, cfg_bit, cfg_abort, rb_req,
    input  bitfile, cfg_busy, cfg_done, cfg_error, cfg_loaded, rb_bit, rb_valid
  );
  modport slave (
    input  cfg_valid, cfg_bit, cfg_abort, rb_req,
    output bitfile, cfg_busy, cfg_done, cfg_error, cfg_loaded, rb_bit, rb_valid
  );
`else
  modport master (
    output cfg_valid, cfg_bit, cfg_abort,
    input  bitfile, cfg_busy, cfg_done, cfg_error, cfg_loaded
  );
  modport slave (
    input  cfg_valid, cfg_bit, cfg_abort,
    output bitfile, cfg_busy, cfg_done, cfg_error, cfg_loaded
  );
`endif
endinterface

// File: rtl/config_loader.sv
// rtl/config_loader.sv - Sync-hunting serial frame loader with even-parity commit; optional readback via CFG_READBACK_EN
module config_loader #(
  parameter int                    CFG_WIDTH  = 8,
  parameter int                    SYNC_WIDTH = 8,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  config_loader_if.slave    cfg
);

  localparam int CNT_W = $clog2(CFG_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_WIDTH - 1);

  typedef enum logic [1:0] {HUNT, LOAD, PARITY} state_t;

  state_t                state, state_n;
  logic [SYNC_WIDTH-1:0] sync_q, sync_n, sync_shift;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic [CFG_WIDTH-1:0]  shadow_q, shadow_n;
  logic [CFG_WIDTH-1:0]  bitfile_q, bitfile_n;
  logic                  loaded_q, loaded_n;
  logic                  done_q, done_n;
  logic                  error_q, error_n;
  logic                  busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      sync_q    <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      bitfile_q <= '0;
      loaded_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      sync_q    <= sync_n;
      cnt_q     <= cnt_n;
      shadow_q  <= shadow_n;
      bitfile_q <= bitfile_n;
      loaded_q  <= loaded_n;
      done_q    <= done_n;
      error_q   <= error_n;
      busy_q    <= (state_n == LOAD) || (state_n == PARITY);
    end
  end

  always_comb begin
    state_n    = state;
    sync_n     = sync_q;
    cnt_n      = cnt_q;
    shadow_n   = shadow_q;
    bitfile_n  = bitfile_q;
    loaded_n   = loaded_q;
    done_n     = 1'b0;
    error_n    = 1'b0;
    sync_shift = {sync_q[SYNC_WIDTH-2:0], cfg.cfg_bit};

    // Abort wins over a coincident valid bit; the committed bitfile survives it.
    if (cfg.cfg_abort) begin
      state_n  = HUNT;
      sync_n   = '0;
      cnt_n    = '0;
      shadow_n = '0;
    end else if (cfg.cfg_valid) begin
      unique case (state)
        HUNT: begin
          if (sync_shift == SYNC_WORD) begin
            state_n = LOAD;
            cnt_n   = '0;
            sync_n  = '0;
          end else begin
            sync_n  = sync_shift;
          end
        end
        LOAD: begin
          shadow_n = {shadow_q[CFG_WIDTH-2:0], cfg.cfg_bit};
          cnt_n    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_n = PARITY;
        end
        PARITY: begin
          state_n = HUNT;
          sync_n  = '0;
          cnt_n   = '0;
          if ((^shadow_q ^ cfg.cfg_bit) == 1'b0) begin
            bitfile_n = shadow_q;
            loaded_n  = 1'b1;
            done_n    = 1'b1;
          end else begin
            error_n   = 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  assign cfg.bitfile    = bitfile_q;
  assign cfg.cfg_busy   = busy_q;
  assign cfg.cfg_done   = done_q;
  assign cfg.cfg_error  = error_q;
  assign cfg.cfg_loaded = loaded_q;

`ifdef CFG_READBACK_EN
  logic [CFG_WIDTH-1:0] rb_sr;
  logic [CNT_W-1:0]     rb_cnt;

  // The shifter drains to zero, so rb_bit idles low without extra gating.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_sr  <= '0;
      rb_cnt <= '0;
    end else if (rb_cnt != '0) begin
      rb_sr  <= {rb_sr[CFG_WIDTH-2:0], 1'b0};
      rb_cnt <= rb_cnt - CNT_W'(1);
    end else if (cfg.rb_req && (state == HUNT) && !busy_q) begin
      rb_sr  <= bitfile_q;
      rb_cnt <= CNT_W'(CFG_WIDTH);
    end
  end

  assign cfg.rb_valid = (rb_cnt != '0);
  assign cfg.rb_bit   = rb_sr[CFG_WIDTH-1];
`endif

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - Scoreboard bench for config_loader; readback checks under CFG_READBACK_EN
module tb_config_loader;

  localparam int W = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef struct {
    bit         is_done;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  config_loader_if #(.CFG_WIDTH(W)) bus ();

  config_loader #(.CFG_WIDTH(W), .SYNC_WIDTH(8), .SYNC_WORD(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .cfg (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  exp_t sb[$];
  exp_t got;
  bit   hist[$];

  logic [7:0] nxt_bitfile = '0, exp_bitfile = '0;
  logic       nxt_loaded  = 1'b0, exp_loaded = 1'b0;
  logic       nxt_busy    = 1'b0, exp_busy   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: earliest SYNC occurrence in the bits seen since the loader last started hunting.
  function automatic int find_sync();
    logic [7:0] w;
    for (int e = 7; e < hist.size(); e++) begin
      w = '0;
      for (int k = 0; k < 8; k++) w = {w[6:0], hist[e-7+k]};
      if (w == SYNC) return e;
    end
    return -1;
  endfunction

  task automatic model_bit(input bit b);
    int e;
    logic [7:0] p;
    hist.push_back(b);
    e = find_sync();
    if (e >= 0 && hist.size() == e + W + 2) begin
      for (int k = 0; k < W; k++) p[W-1-k] = hist[e+1+k];
      if ((^p ^ hist[e+W+1]) == 1'b0) begin
        sb.push_back('{1'b1, p});
        nxt_bitfile = p;
        nxt_loaded  = 1'b1;
      end else begin
        sb.push_back('{1'b0, nxt_bitfile});
      end
      hist.delete();
      nxt_busy = 1'b0;
    end else begin
      nxt_busy = (e >= 0);
    end
  endtask

  always @(posedge clk) begin
    exp_bitfile <= nxt_bitfile;
    exp_loaded  <= nxt_loaded;
    exp_busy    <= nxt_busy;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("bitfile", 32'(bus.bitfile), 32'(exp_bitfile));
      check("cfg_loaded", 32'(bus.cfg_loaded), 32'(exp_loaded));
      check("cfg_busy", 32'(bus.cfg_busy), 32'(exp_busy));
      if (bus.cfg_done || bus.cfg_error) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pulse: done=%0b error=%0b with nothing expected at %0t",
                   bus.cfg_done, bus.cfg_error, $time);
        end else begin
          got = sb.pop_front();
          check("pulse_done", 32'(bus.cfg_done), 32'(got.is_done));
          check("pulse_error", 32'(bus.cfg_error), 32'(!got.is_done));
          check("pulse_bitfile", 32'(bus.bitfile), 32'(got.val));
        end
      end
    end
  end

  task automatic send_bit(input bit b, input int gap);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1;
    bus.cfg_bit   = b;
    model_bit(b);
    repeat (gap) begin
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      bus.cfg_bit   = 1'($urandom);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
  endtask

  task automatic send_frame(input logic [7:0] v, input bit par, input int gap);
    send_byte(SYNC, gap);
    send_byte(v, gap);
    send_bit(par, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      bus.cfg_bit   = 1'($urandom);
    end
  endtask

  task automatic do_abort();
    @(posedge clk); #1;
    bus.cfg_abort = 1'b1;
    bus.cfg_valid = 1'($urandom);
    bus.cfg_bit   = 1'($urandom);
    hist.delete();
    nxt_busy = 1'b0;
    @(posedge clk); #1;
    bus.cfg_abort = 1'b0;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.cfg_valid = 1'($urandom);
    bus.cfg_bit   = 1'($urandom);
    bus.cfg_abort = 1'b0;
    hist.delete();
    nxt_bitfile = '0;
    nxt_loaded  = 1'b0;
    nxt_busy    = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] payload;
    bit         good;
    int         abort_at;
    bus.cfg_valid = 1'b0;
    bus.cfg_bit   = 1'b0;
    bus.cfg_abort = 1'b0;
`ifdef CFG_READBACK_EN
    bus.rb_req = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    send_frame(8'hB2, 1'b0, 0);
    idle(3);

    do_reset();
    send_frame(8'hB2, 1'b1, 0);
    idle(3);

    do_reset();
    send_byte(8'h5A, 1);
    send_byte(8'h3C, 1);
    send_frame(8'h0F, 1'b0, 1);
    idle(3);

    do_reset();
    send_frame(8'hB2, 1'b0, 0);
    send_byte(SYNC, 0);
    for (int i = 0; i < 4; i++) send_bit(1'(i % 2), 0);
    do_abort();
    send_frame(8'h81, 1'b0, 0);
    idle(3);

    do_reset();
    send_frame(8'hB2, 1'b0, 0);
    send_byte(SYNC, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    do_reset();
    send_frame(8'h7E, 1'b0, 0);
    idle(3);

`ifdef CFG_READBACK_EN
    begin
      logic [7:0] rb_exp;
      do_reset();
      send_frame(8'hB2, 1'b0, 0);
      idle(3);
      rb_exp = 8'hB2;
      @(posedge clk); #1 bus.rb_req = 1'b1;
      @(posedge clk); #1 bus.rb_req = 1'b0;
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        check("rb_valid_active", 32'(bus.rb_valid), 32'd1);
        check("rb_bit", 32'(bus.rb_bit), 32'(rb_exp[W-1-i]));
        if (i == 2) bus.rb_req = 1'b1;
        if (i == 3) bus.rb_req = 1'b0;
      end
      repeat (3) begin
        @(negedge clk);
        check("rb_valid_idle", 32'(bus.rb_valid), 32'd0);
        check("rb_bit_idle", 32'(bus.rb_bit), 32'd0);
      end
    end
`endif

    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 99) < 5) do_reset();
      repeat ($urandom_range(0, 6)) send_bit(1'($urandom), $urandom_range(0, 2));
      payload  = 8'($urandom);
      good     = ($urandom_range(0, 9) < 7);
      abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
      send_byte(SYNC, $urandom_range(0, 1));
      for (int i = 0; i < W; i++) begin
        if (i == abort_at) do_abort();
        send_bit(payload[W-1-i], $urandom_range(0, 2));
      end
      send_bit((^payload) ^ !good, $urandom_range(0, 2));
    end
    idle(4);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
